// File: rtl/cmp_sweep_driver.sv
// Self-test sweep driver for the WIDTH-bit comparator: walks every input word, checks the fed-back
// response against EXPECT_MASK. Optional macro SWEEP_STOP_ON_ERR_EN ends the sweep at the first mismatch.
module cmp_sweep_driver #(
    parameter int unsigned                WIDTH       = 4,
    parameter int unsigned                HOLD        = 5,
    parameter logic [(1 << WIDTH) - 1:0]  EXPECT_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] out_word,
    input  logic             in_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_word
);

    localparam int unsigned NWORDS = 1 << WIDTH;
    localparam int unsigned HW     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [WIDTH:0] LAST_W = (WIDTH + 1)'(NWORDS - 1);
    localparam logic [HW-1:0]  LAST_H = HW'(HOLD - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

    state_t          state;
    logic [WIDTH:0]  w;
    logic [HW-1:0]   h;
    logic            mismatch_c;
    logic            stop_c;
    logic [WIDTH:0]  err_next_c;

    // The response is only judged on the last hold cycle, after the comparator has settled.
    assign mismatch_c = (h == LAST_H) && (in_result != EXPECT_MASK[w[WIDTH-1:0]]);
    assign err_next_c = err_count + (WIDTH + 1)'(mismatch_c);

`ifdef SWEEP_STOP_ON_ERR_EN
    assign stop_c = (w == LAST_W) || mismatch_c;
`else
    assign stop_c = (w == LAST_W);
`endif

    assign out_word = w[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            w               <= '0;
            h               <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_word  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    w <= '0;
                    h <= '0;
                    if (start) begin
                        state           <= DRIVE;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_word  <= '0;
                    end
                end
                DRIVE: begin
                    if (h == LAST_H) begin
                        h <= '0;
                        if (mismatch_c) begin
                            err_count <= err_next_c;
                            if (!first_err_valid) begin
                                first_err_valid <= 1'b1;
                                first_err_word  <= w[WIDTH-1:0];
                            end
                        end
                        // Leaving DRIVE: the final sample is already folded into err_next_c.
                        if (stop_c) begin
                            state <= FINISH;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next_c == '0);
                        end else begin
                            w <= w + (WIDTH + 1)'(1);
                        end
                    end else begin
                        h <= h + HW'(1);
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    w     <= '0;
                    h     <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// Bench for cmp_sweep_driver: two instances (HOLD=5 and HOLD=3) driving a behavioural comparator
// with a programmable truth table and output delay, checked against a sweep-level reference.
module tb_cmp_sweep_driver;

    localparam int unsigned H5 = 5;
    localparam int unsigned H3 = 3;
    localparam logic [15:0] MASK = 16'h8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start5, start3;
    logic [3:0] ow5, ow3, few5, few3;
    logic       busy5, done5, pass5, fev5, res5;
    logic       busy3, done3, pass3, fev3, res3;
    logic [4:0] err5, err3;

    cmp_sweep_driver #(.WIDTH(4), .HOLD(H5), .EXPECT_MASK(MASK)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .out_word(ow5), .in_result(res5),
        .busy(busy5), .done(done5), .pass(pass5), .err_count(err5),
        .first_err_valid(fev5), .first_err_word(few5));

    cmp_sweep_driver #(.WIDTH(4), .HOLD(H3), .EXPECT_MASK(MASK)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .out_word(ow3), .in_result(res3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_valid(fev3), .first_err_word(few3));

    // Behavioural comparator: truth table lookup on the word driven dly cycles ago.
    logic [15:0] tbl5, tbl3;
    int          dly5, dly3;
    logic [3:0]  hist5 [1:7];
    logic [3:0]  hist3 [1:7];

    always_ff @(posedge clk) begin
        hist5[1] <= ow5;
        hist3[1] <= ow3;
        for (int j = 2; j <= 7; j++) begin
            hist5[j] <= hist5[j-1];
            hist3[j] <= hist3[j-1];
        end
    end

    always_comb begin
        if (dly5 == 0) res5 = tbl5[ow5];
        else           res5 = tbl5[hist5[dly5]];
        if (dly3 == 0) res3 = tbl3[ow3];
        else           res3 = tbl3[hist3[dly3]];
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: word i is judged on sweep cycle i*hold+hold-1; the comparator then shows the word
    // that was on the bus dly cycles earlier (word 0 before the sweep starts).
    function automatic void ref_sweep(input int hold, input int dly, input logic [15:0] tbl,
                                      output int e_err, output int e_first, output int e_words);
        logic [15:0] m;
        int s, lb, wv;
        bit stopped;
        m = MASK;
        e_err = 0; e_first = 0; e_words = 16; stopped = 0;
        for (int i = 0; i < 16; i++) begin
            if (!stopped) begin
                s  = i * hold + hold - 1;
                lb = s - dly;
                wv = (lb < 0) ? 0 : lb / hold;
                if (tbl[wv] != m[i]) begin
                    if (e_err == 0) e_first = i;
                    e_err++;
`ifdef SWEEP_STOP_ON_ERR_EN
                    stopped = 1;
                    e_words = i + 1;
`endif
                end
            end
        end
    endfunction

    // Pulse start on the chosen instance and observe 120 cycles; cycle 1 is the first after the start edge.
    task automatic sweep(input int which, input int rp_a, input int rp_b,
                         output int bc, output int da, output int dc, output int owb,
                         output int r_err, output logic r_pass, output logic r_fev,
                         output int r_few, output int end_err);
        int hold;
        logic b, d;
        logic [3:0] ow;
        hold = (which == 5) ? H5 : H3;
        bc = 0; da = -1; dc = 0; owb = 0;
        r_err = -1; r_pass = 1'bx; r_fev = 1'bx; r_few = -1; end_err = -1;
        if (which == 5) start5 = 1'b1; else start3 = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            b  = (which == 5) ? busy5 : busy3;
            d  = (which == 5) ? done5 : done3;
            ow = (which == 5) ? ow5 : ow3;
            if (b) begin
                bc++;
                if (ow !== 4'((c - 1) / hold)) owb++;
            end else if (!d && ow !== 4'd0) begin
                owb++;
            end
            if (d) begin
                dc++;
                if (da < 0) begin
                    da     = c;
                    r_err  = (which == 5) ? int'(err5) : int'(err3);
                    r_pass = (which == 5) ? pass5 : pass3;
                    r_fev  = (which == 5) ? fev5 : fev3;
                    r_few  = (which == 5) ? int'(few5) : int'(few3);
                end
            end
            if (which == 5) start5 = (c == rp_a || c == rp_b);
            else            start3 = (c == rp_a || c == rp_b);
        end
        end_err = (which == 5) ? int'(err5) : int'(err3);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ow5, busy5, done5, pass5, err5, fev5, few5} !== 17'd0) begin
                n_bad++;
                $display("FAIL reset_state5 cyc %0d got %h want 0", i, {ow5, busy5, done5, pass5, err5, fev5, few5});
            end
        end
        n_cmp++;
        if ({ow3, busy3, done3, pass3, err3, fev3, few3} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_state3 got %h want 0", {ow3, busy3, done3, pass3, err3, fev3, few3});
        end
    endtask

    // Runs one sweep and compares every observation against the reference; used by scenario tasks below.
    task automatic test_sweep(input string nm, input int which, input int dly, input logic [15:0] tbl,
                              input int rp_a, input int rp_b);
        int bc, da, dc, owb, r_err, r_few, end_err, e_err, e_first, e_words, hold;
        logic r_pass, r_fev;
        hold = (which == 5) ? H5 : H3;
        if (which == 5) begin tbl5 = tbl; dly5 = dly; end
        else            begin tbl3 = tbl; dly3 = dly; end
        ref_sweep(hold, dly, tbl, e_err, e_first, e_words);
        sweep(which, rp_a, rp_b, bc, da, dc, owb, r_err, r_pass, r_fev, r_few, end_err);
        n_cmp++; if (bc !== e_words * hold) begin n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", nm, bc, e_words * hold); end
        n_cmp++; if (da !== e_words * hold + 1) begin n_bad++; $display("FAIL %s done_cycle got %0d want %0d", nm, da, e_words * hold + 1); end
        n_cmp++; if (dc !== 1) begin n_bad++; $display("FAIL %s done_pulses got %0d want 1", nm, dc); end
        n_cmp++; if (owb !== 0) begin n_bad++; $display("FAIL %s out_word_sequence bad_cycles got %0d want 0", nm, owb); end
        n_cmp++; if (r_err !== e_err) begin n_bad++; $display("FAIL %s err_count got %0d want %0d", nm, r_err, e_err); end
        n_cmp++; if (r_pass !== (e_err == 0)) begin n_bad++; $display("FAIL %s pass got %b want %b", nm, r_pass, e_err == 0); end
        n_cmp++; if (r_fev !== (e_err != 0)) begin n_bad++; $display("FAIL %s first_err_valid got %b want %b", nm, r_fev, e_err != 0); end
        n_cmp++; if (r_few !== e_first) begin n_bad++; $display("FAIL %s first_err_word got %0d want %0d", nm, r_few, e_first); end
        n_cmp++; if (end_err !== e_err) begin n_bad++; $display("FAIL %s err_count_hold_in_idle got %0d want %0d", nm, end_err, e_err); end
    endtask

    task automatic test_full_pass();
        test_sweep("full_pass", 5, 0, MASK, -1, -1);
    endtask

    task automatic test_faulted();
        // Words 3 and 10 also answer 1: two mismatches, or a stop at word 3.
        test_sweep("faulted", 5, 0, MASK | 16'h0408, -1, -1);
    endtask

    task automatic test_delay();
        test_sweep("delay3_hold5", 5, 3, MASK, -1, -1);
        test_sweep("delay3_hold3", 3, 3, MASK, -1, -1);
        n_cmp++;
        if (pass3 !== 1'b0 || err3 == 5'd0) begin
            n_bad++;
            $display("FAIL delay3_hold3_fails got pass=%b err=%0d want pass=0 err>0", pass3, err3);
        end
    endtask

    task automatic test_back_to_back();
        // start during DRIVE (cycle 20) and during FINISH (cycle 81) must both be dropped.
        test_sweep("repulse", 5, 0, MASK, 20, 81);
        n_cmp++;
        if (busy5 !== 1'b0) begin n_bad++; $display("FAIL repulse_idle_after busy got %b want 0", busy5); end
    endtask

    task automatic test_mid_reset();
        int dc;
        tbl5 = MASK | 16'h0008; dly5 = 0;
        start5 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start5 = 1'b0;
        end
        n_cmp++;
        if (err5 !== 5'd1 || busy5 !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_before got err=%0d busy=%b want err=1 busy=1", err5, busy5);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({busy5, done5, ow5, err5, fev5} !== 12'd0) begin
            n_bad++;
            $display("FAIL midreset_after got busy=%b done=%b ow=%0d err=%0d fev=%b want all 0", busy5, done5, ow5, err5, fev5);
        end
        dc = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done5 || busy5) dc++;
        end
        n_cmp++;
        if (dc !== 0) begin n_bad++; $display("FAIL midreset_quiet active_cycles got %0d want 0", dc); end
        test_sweep("after_reset", 5, 0, MASK | 16'h0008, -1, -1);
    endtask

    task automatic test_random();
        int which, hold, dly;
        logic [15:0] faults;
        for (int it = 0; it < 8; it++) begin
            which  = ($urandom_range(0, 1) == 0) ? 5 : 3;
            hold   = (which == 5) ? H5 : H3;
            dly    = $urandom_range(0, hold);
            faults = 16'($urandom) & 16'($urandom) & 16'($urandom);
            if (it == 0) faults = 16'h0000;
            test_sweep($sformatf("random%0d_h%0d_d%0d", it, hold, dly), which, dly, MASK ^ faults, -1, -1);
        end
    endtask

    initial begin
        rst = 1'b1; start5 = 1'b0; start3 = 1'b0;
        tbl5 = MASK; tbl3 = MASK; dly5 = 0; dly3 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_full_pass();
        test_faulted();
        test_delay();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
